// File: rtl/simd_program_sequencer.sv
// simd_program_sequencer
//   Loadable program driver and lane-wise result checker for the SIMD vector
//   processor. Issues one instruction per accepted cycle, compares the
//   processor result against per-step expected vectors and reports error
//   status (saturating count, first failing pc and lane mask).
//
// Optional feature: define SEQ_TRACE_EN to add a DEPTH-entry trace RAM that
//   captures `result` at each accepted step (read via trace_raddr/trace_rdata,
//   one-cycle latency). Undefined: trace_rdata is tied to 0.
//
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   prog_we/addr/instr/expect/chk   program memory write port (IDLE/FIN only)
//   prog_len              steps to run (0..DEPTH), latched at start
//   start, abort, stall   run control
//   result                processor result, valid in the issue cycle
//   instruction, instr_valid   issued instruction (combinational from mem[pc])
//   pc, busy, done        run status
//   mismatch              one-cycle pulse after a failing compare
//   err_count, first_err_pc, first_err_lanes   error status
//   trace_raddr, trace_rdata   trace RAM read port
module simd_program_sequencer #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned LANE_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned ERR_W  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      prog_we,
  input  logic [ADDR_W-1:0]         prog_addr,
  input  logic [31:0]               prog_instr,
  input  logic [LANES*LANE_W-1:0]   prog_expect,
  input  logic                      prog_chk,
  input  logic [ADDR_W:0]           prog_len,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      stall,
  input  logic [LANES*LANE_W-1:0]   result,
  output logic [31:0]               instruction,
  output logic                      instr_valid,
  output logic [ADDR_W-1:0]         pc,
  output logic                      busy,
  output logic                      done,
  output logic                      mismatch,
  output logic [ERR_W-1:0]          err_count,
  output logic [ADDR_W-1:0]         first_err_pc,
  output logic [LANES-1:0]          first_err_lanes,
  input  logic [ADDR_W-1:0]         trace_raddr,
  output logic [LANES*LANE_W-1:0]   trace_rdata
);

  localparam int unsigned VEC_W = LANES * LANE_W;
  localparam int unsigned LEN_W = ADDR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t             state;
  logic [LEN_W-1:0]   len;
  logic [31:0]        mem_instr  [DEPTH];
  logic [VEC_W-1:0]   mem_expect [DEPTH];
  logic [DEPTH-1:0]   mem_chk;

  logic               step_acc_c;
  logic [LANES-1:0]   lane_fail_c;
  logic               step_fail_c;
  logic               last_step_c;
  logic               prog_wr_c;

  // A step retires on a clean edge in RUN; abort takes priority over it.
  assign step_acc_c  = (state == S_RUN) && !stall && !abort;
  assign step_fail_c = mem_chk[pc] && (|lane_fail_c);
  assign last_step_c = (LEN_W'(pc) == (len - LEN_W'(1)));
  assign prog_wr_c   = prog_we && (state != S_RUN) && (LEN_W'(prog_addr) < LEN_W'(DEPTH));

  // Per-lane compare of the live result against this step's expected vector.
  always_comb begin
    lane_fail_c = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_fail_c[i] = (result[i*LANE_W +: LANE_W] != mem_expect[pc][i*LANE_W +: LANE_W]);
    end
  end

  // Instruction is presented in the same cycle the processor consumes it.
  assign instruction = (state == S_RUN) ? mem_instr[pc] : 32'd0;

  // Program storage, intentionally not reset.
  always_ff @(posedge clk) begin
    if (prog_wr_c) begin
      mem_instr[prog_addr]  <= prog_instr;
      mem_expect[prog_addr] <= prog_expect;
      mem_chk[prog_addr]    <= prog_chk;
    end
  end

  // Run control FSM with registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      len             <= '0;
      pc              <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      instr_valid     <= 1'b0;
      mismatch        <= 1'b0;
      err_count       <= '0;
      first_err_pc    <= '0;
      first_err_lanes <= '0;
    end else begin
      mismatch <= 1'b0;
      unique case (state)
        S_IDLE, S_FIN: begin
          if (start) begin
            pc              <= '0;
            err_count       <= '0;
            first_err_pc    <= '0;
            first_err_lanes <= '0;
            len             <= (prog_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : prog_len;
            if (prog_len == '0) begin
              state       <= S_FIN;
              done        <= 1'b1;
              busy        <= 1'b0;
              instr_valid <= 1'b0;
            end else begin
              state       <= S_RUN;
              done        <= 1'b0;
              busy        <= 1'b1;
              instr_valid <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (abort) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            instr_valid <= 1'b0;
          end else if (step_acc_c) begin
            if (step_fail_c) begin
              mismatch <= 1'b1;
              if (err_count != '1) begin
                err_count <= err_count + ERR_W'(1);
              end
              if (err_count == '0) begin
                first_err_pc    <= pc;
                first_err_lanes <= lane_fail_c;
              end
            end
            if (last_step_c) begin
              state       <= S_FIN;
              busy        <= 1'b0;
              done        <= 1'b1;
              instr_valid <= 1'b0;
            end else begin
              pc <= pc + ADDR_W'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SEQ_TRACE_EN
  logic [VEC_W-1:0] trace_mem [DEPTH];

  // Capture the result of every retired step at its pc.
  always_ff @(posedge clk) begin
    if (step_acc_c) begin
      trace_mem[pc] <= result;
    end
  end

  // Registered read port, usable in any state.
  always_ff @(posedge clk) begin
    trace_rdata <= trace_mem[trace_raddr];
  end
`else
  logic unused_trace;
  assign unused_trace = ^trace_raddr;
  assign trace_rdata  = '0;
`endif

endmodule
